// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl (with full_adder cell)
// Brief    : Bit-serial add/subtract controller time-sharing one full_adder
//            cell across all WIDTH bit positions, LSB first.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_fa_s;
    logic             w_fa_cout;

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1; the add carry-in is ignored.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    if (r_cnt == C_LAST) begin
                        // Carry flop holds the carry into the MSB on this cycle.
                        r_sum   <= {w_fa_s, r_res[WIDTH-1:1]};
                        r_cout  <= w_fa_cout;
                        r_ovf   <= r_carry ^ w_fa_cout;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Self-checking bench for serial_add_ctrl (WIDTH=8) against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Result packed as {cout, overflow, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
        logic [W-1:0] yy;
        logic         ci;
        logic [W:0]   t;
        logic         ov;
        yy = s ? ~y : y;
        ci = s ? 1'b1 : c;
        t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
        ov = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return {t[W], ov, t[W-1:0]};
    endfunction

    // Presents a request for one cycle (expects ready), then scrambles the operands.
    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s);
        @(negedge clk);
        a = x; b = y; cin = c; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int bcnt, output logic [W+1:0] res);
        bit got;
        got  = 1'b0;
        cyc  = 0;
        bcnt = 0;
        res  = 'x;
        while (!got && cyc < 4 * W) begin
            if (busy) bcnt++;
            if (done) begin
                res = {cout, overflow, sum};
                got = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) begin
            n_err++;
            $display("FAIL wait_done: no done within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ready, busy, done, sum, cout, overflow} !== {3'b100, {W{1'b0}}, 2'b00}) begin
            n_err++;
            $display("FAIL reset_state: got r=%b b=%b d=%b sum=%h co=%b ov=%b, want 1 0 0 00 0 0",
                     ready, busy, done, sum, cout, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int cyc, bcnt;
        logic [W+1:0] res;
        apply(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done(cyc, bcnt, res);
        n_cmp++;
        if (res !== ref_op(8'h0F, 8'h01, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL add_0f_01: got %h want %h", res, ref_op(8'h0F, 8'h01, 1'b0, 1'b0));
        end
        n_cmp++;
        if (cyc !== W) begin
            n_err++;
            $display("FAIL latency: got %0d edges want %0d", cyc, W);
        end
        n_cmp++;
        if (bcnt !== W) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d want %0d", bcnt, W);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, ready, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL done_pulse: got done=%b ready=%b busy=%b want 0 1 0", done, ready, busy);
        end
        apply(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(cyc, bcnt, res);
        n_cmp++;
        if (res !== {1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL add_wrap: got %h want %h", res, {1'b1, 1'b0, 8'h00});
        end
        apply(8'h7F, 8'h00, 1'b1, 1'b0);
        wait_done(cyc, bcnt, res);
        n_cmp++;
        if (res !== {1'b0, 1'b1, 8'h80}) begin
            n_err++;
            $display("FAIL add_ovf: got %h want %h", res, {1'b0, 1'b1, 8'h80});
        end
    endtask

    task automatic test_sub();
        int cyc, bcnt;
        logic [W+1:0] res;
        apply(8'h05, 8'h07, 1'b1, 1'b1);
        wait_done(cyc, bcnt, res);
        n_cmp++;
        if (res !== {1'b0, 1'b0, 8'hFE}) begin
            n_err++;
            $display("FAIL sub_5_7: got %h want %h", res, {1'b0, 1'b0, 8'hFE});
        end
        apply(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(cyc, bcnt, res);
        n_cmp++;
        if (res !== {1'b1, 1'b1, 8'h7F}) begin
            n_err++;
            $display("FAIL sub_80_1: got %h want %h", res, {1'b1, 1'b1, 8'h7F});
        end
    endtask

    task automatic test_start_in_run();
        int cyc, bcnt;
        logic [W+1:0] res;
        apply(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt, res);
        n_cmp++;
        if (res !== ref_op(8'h12, 8'h34, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL start_in_run: got %h want %h", res, ref_op(8'h12, 8'h34, 1'b0, 1'b0));
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL no_queue: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        logic [W+1:0] res;
        apply(8'h30, 8'h0C, 1'b0, 1'b0);
        wait_done(cyc, bcnt, res);
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'hC3; b = 8'h3C;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_no_gap: got busy=%b want 1", busy);
        end
        wait_done(cyc, bcnt, res);
        n_cmp++;
        if (cyc + 1 !== W + 1) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", cyc + 1, W + 1);
        end
        n_cmp++;
        if (res !== {1'b0, 1'b0, 8'h03}) begin
            n_err++;
            $display("FAIL b2b_result: got %h want %h", res, {1'b0, 1'b0, 8'h03});
        end
        @(negedge clk);
    endtask

    task automatic test_operand_change();
        int cyc, bcnt;
        logic [W+1:0] res;
        apply(8'h5A, 8'h21, 1'b1, 1'b0);
        a = 8'hFF; b = 8'hFF; cin = 1'b0; sub = 1'b1;
        wait_done(cyc, bcnt, res);
        n_cmp++;
        if (res !== {1'b0, 1'b0, 8'h7C}) begin
            n_err++;
            $display("FAIL operand_change: got %h want %h", res, {1'b0, 1'b0, 8'h7C});
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int cyc, bcnt, seen;
        logic [W+1:0] res;
        apply(8'h44, 8'h11, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready, busy, done, sum, cout, overflow} !== {3'b100, {W{1'b0}}, 2'b00}) begin
            n_err++;
            $display("FAIL async_reset: got r=%b b=%b d=%b sum=%h co=%b ov=%b, want 1 0 0 00 0 0",
                     ready, busy, done, sum, cout, overflow);
        end
        seen = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            if (done) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_abort: got %0d done pulses want 0", seen);
        end
        apply(8'h10, 8'h20, 1'b0, 1'b0);
        wait_done(cyc, bcnt, res);
        n_cmp++;
        if (res !== {1'b0, 1'b0, 8'h30}) begin
            n_err++;
            $display("FAIL after_reset: got %h want %h", res, {1'b0, 1'b0, 8'h30});
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int cyc, bcnt;
        logic [W+1:0] res;
        logic [W-1:0] x, y;
        logic c, s;
        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            s = 1'($urandom);
            apply(x, y, c, s);
            wait_done(cyc, bcnt, res);
            n_cmp++;
            if (res !== ref_op(x, y, c, s)) begin
                n_err++;
                $display("FAIL sweep[%0d] a=%h b=%h cin=%b sub=%b: got %h want %h",
                         i, x, y, c, s, res, ref_op(x, y, c, s));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_in_run();
        test_back_to_back();
        test_operand_change();
        test_async_reset();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
